// File: rtl/serial_subtractor_pkg.sv
// Shared constants and FSM state encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: A - B - Bin, producing difference and borrow-out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic DIFF,
  output logic BORROW
);

  // Borrow when B exceeds A, or when A equals B and a borrow comes in.
  always_comb begin
    DIFF   = A ^ B ^ Bin;
    BORROW = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A-B LSB first, one bit per clock.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bor;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_bout;

  full_subtractor u_fs (
    .A      (r_a[0]),
    .B      (r_b[0]),
    .Bin    (r_bor),
    .DIFF   (w_d),
    .BORROW (w_bout)
  );

  // Control FSM and datapath: accept operands, shift one bit per RUN cycle, publish result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_bor    <= 1'b0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_res   <= '0;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bor <= w_bout;
          if (r_cnt == LAST_BIT) begin
            // Final bit: expose the full result; counter is left as-is so it never wraps.
            r_diff   <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign DIFF   = r_diff;
  assign BORROW = r_borrow;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH bits: minuend, captured on the accepting edge.
REQ-006 SHALL have port B, input, WIDTH bits: subtrahend, captured on the accepting edge.
REQ-007 SHALL have port DIFF, output, WIDTH bits: registered result A-B modulo 2^WIDTH.
REQ-008 SHALL have port BORROW, output, 1 bit: registered final borrow-out (1 when A<B unsigned).
REQ-009 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse, high while in DONE.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, SHALL load A and B into shift registers, clear the borrow flip-flop and the bit counter, and go to RUN on that edge (the accepting edge E0).
REQ-013 In RUN, each edge SHALL process one bit, LSB first, using the current LSBs a, b and the borrow-in bin:
- difference bit d = a^b^bin
- bout = (~a&b) | (~(a^b)&bin)
REQ-014 On each RUN edge, SHALL shift d into the MSB of the result shift register, shift both operand registers right by one, store bout, and increment the counter.
REQ-015 On the edge that processes bit WIDTH-1 (edge E_WIDTH), SHALL go to DONE, update DIFF to the complete result and BORROW to bout.
REQ-016 Total latency SHALL be WIDTH edges from E0 to done=1; done SHALL stay high for exactly one cycle.
REQ-017 From DONE, SHALL return to IDLE unconditionally on the next edge.
REQ-018 SHALL ignore start in RUN and DONE (no restart, no operand reload); A and B changing during RUN SHALL have no effect.
REQ-019 DIFF and BORROW SHALL hold their last result until the next completion; they SHALL NOT show partial values during RUN.
REQ-020 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL not wrap during a legal operation.

Reset
REQ-021 rst=1 at an edge SHALL force IDLE and clear DIFF, BORROW, busy, done, the shift registers, the borrow flip-flop and the counter to 0, in any state.
REQ-022 rst SHALL take priority over start; reset during RUN SHALL abort the operation with no done pulse.

Structure
REQ-023 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant in a shared package.
REQ-024 SHALL instantiate one combinational sub-module, full_subtractor (ports A, B, Bin, DIFF, BORROW), for the per-bit computation.

Verification
REQ-025 WIDTH=8, A=0x5A, B=0x3C, start pulse -> done exactly 8 edges after E0, DIFF=0x1E, BORROW=0, busy high for 8 cycles.
REQ-026 A=0x3C, B=0x5A -> DIFF=0xE2, BORROW=1.
REQ-027 A=0x00, B=0x01 -> DIFF=0xFF, BORROW=1 (full borrow ripple); A=0xFF, B=0xFF -> DIFF=0x00, BORROW=0.
REQ-028 Start at E0 with A=0x10, B=0x01, then start=1 and A=0xFF mid-RUN -> exactly one done pulse, DIFF=0x0F; the second start has no effect.
REQ-029 rst asserted at edge 4 of a RUN -> next cycle shows IDLE and all outputs 0, with no done pulse; a new start afterwards completes correctly.
REQ-030 A start on the edge just after DONE (in IDLE) SHALL be accepted, giving back-to-back results with one idle cycle between operations.
